// File: rtl/param_pc_serial_unit.sv
// param_pc_serial_unit
//
// Purpose:
//   Program-counter unit for a bit-serial / subword-serial core. It holds the
//   architectural PC, assembles a branch/jump target one subword at a time
//   into addr_reg, and presents the PC and PC+4 values as rotating streams
//   so the narrow datapath can consume them one subword per cycle.
//
// Parameters:
//   P_NBITS   datapath subword width (1, 2, 4, 8, 16 or 32)
//   RESET_PC  PC value loaded by reset
//
// Ports:
//   clk          sole clock, all state on the rising edge
//   reset        synchronous, active-high
//   last_uop     final micro-op of the instruction; the PC commits
//   take_target  with last_uop: redirect to the assembled target
//   alu_sub      current ALU result subword
//   addr_en      write alu_sub into addr_reg at the current subword index
//   addr_dir     0 = subword index counts up, 1 = counts down
//   stream_en    rotate both PC streams by one subword
//   stream_sel   1 = stream_out carries PC+4, 0 = PC
//   trap_valid   trap redirect request (only with PC_TRAP_REDIRECT_EN)
//   trap_vec     trap vector (only with PC_TRAP_REDIRECT_EN)
//   stream_out   low subword of the selected stream
//   stream_last  stream_out is the final subword of the word
//   addr_reg     deserialised target address
//   pc           architectural PC
//
// Optional feature:
//   Define PC_TRAP_REDIRECT_EN to add the trap redirect ports; a trap then
//   has top priority when the PC commits.

module param_pc_serial_unit #(
  parameter int unsigned P_NBITS  = 4,
  parameter logic [31:0] RESET_PC = 32'h00080000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               last_uop,
  input  logic               take_target,
  input  logic [P_NBITS-1:0] alu_sub,
  input  logic               addr_en,
  input  logic               addr_dir,
  input  logic               stream_en,
  input  logic               stream_sel,
`ifdef PC_TRAP_REDIRECT_EN
  input  logic               trap_valid,
  input  logic [31:0]        trap_vec,
`endif
  output logic [P_NBITS-1:0] stream_out,
  output logic               stream_last,
  output logic [31:0]        addr_reg,
  output logic [31:0]        pc
);

  localparam int unsigned N  = 32 / P_NBITS;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] idx;
  logic [CW-1:0] idx_next;
  logic [CW-1:0] cnt;
  logic [31:0]   pc_stream;
  logic [31:0]   pc4_stream;
  logic [31:0]   pc_stream_rot;
  logic [31:0]   pc4_stream_rot;
  logic [31:0]   target;
  logic [31:0]   next_pc;

  // The jump target takes its top subword straight from the ALU in the
  // committing cycle, so the instruction does not need one more cycle to
  // store it first; the rest comes from what was already assembled.
  always_comb begin
    target = addr_reg;
    target[31 -: P_NBITS] = alu_sub;
  end

  // Next PC selection, trap first when the feature is built in.
  always_comb begin
    next_pc = pc + 32'd4;
    if (take_target) begin
      next_pc = target;
    end
`ifdef PC_TRAP_REDIRECT_EN
    if (trap_valid) begin
      next_pc = trap_vec;
    end
`endif
  end

  // Subword index steps modulo N in either direction so targets can be
  // assembled LSB-first or MSB-first.
  always_comb begin
    if (addr_dir) begin
      idx_next = (idx == '0) ? LAST : idx - 1'b1;
    end else begin
      idx_next = (idx == LAST) ? '0 : idx + 1'b1;
    end
  end

  // A full-width subword has nothing to rotate, and the narrower case must
  // not form an empty part-select, so the rotation is chosen at elaboration.
  generate
    if (P_NBITS == 32) begin : g_no_rot
      assign pc_stream_rot  = pc_stream;
      assign pc4_stream_rot = pc4_stream;
      assign stream_last    = 1'b1;
    end else begin : g_rot
      assign pc_stream_rot  = {pc_stream[P_NBITS-1:0], pc_stream[31:P_NBITS]};
      assign pc4_stream_rot = {pc4_stream[P_NBITS-1:0], pc4_stream[31:P_NBITS]};
      assign stream_last    = (cnt == LAST);
    end
  endgenerate

  assign stream_out = stream_sel ? pc4_stream[P_NBITS-1:0] : pc_stream[P_NBITS-1:0];

  // All state. The address write uses the index before any clear so a
  // write in the committing cycle still lands where expected; committing
  // reloads both streams and wins over a same-cycle rotate.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_PC;
      addr_reg   <= '0;
      idx        <= '0;
      cnt        <= '0;
      pc_stream  <= RESET_PC;
      pc4_stream <= RESET_PC + 32'd4;
    end else begin
      if (addr_en) begin
        addr_reg[32'(idx) * P_NBITS +: P_NBITS] <= alu_sub;
      end
      if (last_uop) begin
        idx <= '0;
      end else if (addr_en) begin
        idx <= idx_next;
      end
      if (last_uop) begin
        pc         <= next_pc;
        pc_stream  <= next_pc;
        pc4_stream <= next_pc + 32'd4;
        cnt        <= '0;
      end else if (stream_en) begin
        pc_stream  <= pc_stream_rot;
        pc4_stream <= pc4_stream_rot;
        cnt        <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/param_pc_serial_unit.md
PARAM_PC_SERIAL_UNIT -- requirements
Module: param_pc_serial_unit

Interface
REQ-001 SHALL have parameter P_NBITS, default 4: datapath subword width; legal values 1, 2, 4, 8, 16, 32.
REQ-002 SHALL have parameter RESET_PC, default 32'h00080000: PC value after reset.
REQ-003 SHALL use derived constant N = 32/P_NBITS: subwords per word, counters of width max(1,clog2(N)).
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 last_uop  in  1  final micro-op of instruction; PC commits.
REQ-007 take_target  in  1  at last_uop: redirect to assembled branch/jump target.
REQ-008 alu_sub  in  P_NBITS  current ALU result subword.
REQ-009 addr_en  in  1  write alu_sub into address register.
REQ-010 addr_dir  in  1  0 = subword index increments, 1 = index decrements.
REQ-011 stream_en  in  1  rotate PC streams by one subword.
REQ-012 stream_sel  in  1  1 = stream_out carries PC+4, 0 = PC.
REQ-013 stream_out  out  P_NBITS  current low subword of selected stream.
REQ-014 stream_last  out  1  stream_out is the final (Nth) subword.
REQ-015 addr_reg  out  32  deserialised target address.
REQ-016 pc  out  32  architectural PC.
REQ-017 trap_valid  in  1 / trap_vec  in  32: trap redirect request and vector (present only with PC_TRAP_REDIRECT_EN).

Function
REQ-018 pc SHALL update only when last_uop=1; otherwise hold.
REQ-019 Next PC at last_uop SHALL be, by priority: trap_vec (if enabled and trap_valid), then {alu_sub, addr_reg[31-P_NBITS:0]} if take_target, else pc+4.
REQ-020 pc+4 SHALL be modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-021 Address index idx SHALL, on addr_en, write alu_sub into addr_reg[idx*P_NBITS +: P_NBITS], then step +1 (addr_dir=0) or -1 (addr_dir=1) modulo N.
REQ-022 idx SHALL clear to 0 on last_uop; a coincident addr_en SHALL still write at the pre-clear idx.
REQ-023 Two 32-bit rotate registers (PC stream, PC+4 stream) SHALL load next-PC and next-PC+4 on last_uop.
REQ-024 When stream_en=1 and last_uop=0, both streams SHALL rotate right by P_NBITS and stream counter cnt SHALL increment modulo N.
REQ-025 last_uop SHALL override stream_en in the same cycle; cnt clears to 0.
REQ-026 stream_out SHALL be combinational: low P_NBITS of stream selected by stream_sel.
REQ-027 stream_last SHALL be 1 exactly when cnt = N-1; for P_NBITS=32 it SHALL be constant 1.
REQ-028 Streams/cnt with neither stream_en nor last_uop SHALL hold.

Reset
REQ-029 On reset: pc=RESET_PC, addr_reg=0, idx=0, cnt=0, PC stream=RESET_PC, PC+4 stream=RESET_PC+4.
REQ-030 reset SHALL override all inputs in the same cycle, including mid-stream and mid-deserialisation.

Configuration
REQ-031 Macro PC_TRAP_REDIRECT_EN defined: trap_valid/trap_vec ports exist, trap has top priority at last_uop, trap_valid ignored when last_uop=0.
REQ-032 Macro undefined: trap ports absent; behaviour is REQ-019 without the trap term.

Verification (P_NBITS=4)
REQ-033 Reset, stream_sel=0, 8 stream_en cycles -> stream_out 0,0,0,0,8,0,0,0; stream_last only on 8th; pc=0x00080000.
REQ-034 From reset, last_uop, take_target=0 -> pc=0x00080004; stream_sel=1 shows 0x00080008 nibbles LSB-first.
REQ-035 addr_dir=0, addr_en 7 cycles with alu_sub 1..7, then last_uop+take_target with alu_sub=0xA -> pc=0xA7654321, idx=0.
REQ-036 pc=0xFFFFFFFC, last_uop, take_target=0 -> pc=0x00000000; PC+4 stream=0x00000004.
REQ-037 stream_en and last_uop same cycle after 3 rotations -> streams reload, cnt=0, stream_last=0; reset asserted mid-stream -> REQ-029 values next cycle.
REQ-038 With PC_TRAP_REDIRECT_EN: last_uop, take_target=1, trap_valid=1, trap_vec=0x00000100 -> pc=0x00000100.
